// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and limits for the Ibex bus memory responder.
package ibex_mem_resp_pkg;

    localparam int unsigned MaxRespLatency      = 4;
    localparam int unsigned MaxOutstandingLimit = 4;

    // Inverted SECDED(39,32) check bits of an all-zero word.
    localparam logic [6:0] IntgOfZero = 7'h2A;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_entry_t;

endpackage

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted SECDED(39,32) encoder: data in [31:0], inverted check bits in [38:32].
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    always_comb begin
        data_o     = 39'(data_i);
        data_o[32] = ^(data_o & 39'h002606BD25);
        data_o[33] = ^(data_o & 39'h00DEBA8050);
        data_o[34] = ^(data_o & 39'h00413D89AA);
        data_o[35] = ^(data_o & 39'h0031234ED1);
        data_o[36] = ^(data_o & 39'h00C2C1323B);
        data_o[37] = ^(data_o & 39'h002DCC624C);
        data_o[38] = ^(data_o & 39'h0098505586);
        data_o     = data_o ^ 39'h2A00000000;
    end

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side responder for the Ibex req/gnt/rvalid bus, backed by an internal word array.
// Optional write-data integrity checking is enabled by defining IBEX_MEM_RESP_INTG_CHECK_EN.
module ibex_mem_responder
    import ibex_mem_resp_pkg::*;
#(
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned DepthWords     = 1024,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [6:0]  wdata_intg_i,
    output logic [31:0] rdata_o,
    output logic [6:0]  rdata_intg_o,
    output logic        err_o
);

    localparam int unsigned IdxW  = $clog2(DepthWords);
    localparam int unsigned WaitW = $clog2(GntDelay + 2);
    localparam int unsigned OutW  = $clog2(MaxOutstandingLimit + 1);

    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [OutW-1:0]  outstanding_q, outstanding_d;
    logic             gnt_ok_c, accept_c, wr_en_c, intg_ok_c;
    logic [29:0]      word_idx_c;
    logic             in_range_c;
    logic [IdxW-1:0]  mem_idx_c;
    logic [31:0]      mem_q [DepthWords];
    resp_entry_t      entry_c, retire_c;
    resp_entry_t      pipe_q [MaxRespLatency-1];
    logic             rvalid_q, err_q;
    logic [31:0]      rdata_q;
    logic [6:0]       rintg_q;
    logic [38:0]      rd_enc_c;
    logic             unused_bits;

    // Grant-delay qualifier; with no delay every request is eligible immediately.
    if (GntDelay == 0) begin : g_no_delay
        assign gnt_ok_c = 1'b1;
    end else begin : g_delay
        assign gnt_ok_c = (wait_cnt_q >= WaitW'(GntDelay));
    end

    assign gnt_o    = req_i && gnt_ok_c && (outstanding_q < OutW'(MaxOutstanding));
    assign accept_c = req_i && gnt_o;

    assign word_idx_c = 30'((addr_i - BaseAddr) >> 2);
    assign in_range_c = (addr_i >= BaseAddr) && (word_idx_c < 30'(DepthWords));
    assign mem_idx_c  = word_idx_c[IdxW-1:0];

`ifdef IBEX_MEM_RESP_INTG_CHECK_EN
    logic [38:0] wr_enc_c;
    logic        intg_err_q;

    prim_secded_inv_39_32_enc u_wr_enc (
        .data_i (wdata_i),
        .data_o (wr_enc_c)
    );

    assign intg_ok_c = (wr_enc_c[38:32] == wdata_intg_i);

    // Sticky record of any write rejected for bad integrity.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            intg_err_q <= 1'b0;
        end else if (accept_c && we_i && !intg_ok_c) begin
            intg_err_q <= 1'b1;
        end
    end

    assign unused_bits = ^{intg_err_q, wr_enc_c[31:0], rd_enc_c[31:0]};
`else
    assign intg_ok_c   = 1'b1;
    assign unused_bits = ^{wdata_intg_i, rd_enc_c[31:0]};
`endif

    assign wr_en_c = accept_c && we_i && in_range_c && intg_ok_c;

    // Response entry captured at acceptance; reads sample the array before this edge's write.
    always_comb begin
        entry_c       = '0;
        entry_c.valid = accept_c;
        entry_c.err   = !in_range_c || (we_i && !intg_ok_c);
        entry_c.rdata = (in_range_c && !we_i) ? mem_q[mem_idx_c] : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[mem_idx_c][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // The output registers form the final latency stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MaxRespLatency) - 1; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= entry_c;
            for (int i = 1; i < int'(MaxRespLatency) - 1; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    if (RespLatency == 1) begin : g_lat1
        assign retire_c = entry_c;
    end else begin : g_latn
        assign retire_c = pipe_q[RespLatency-2];
    end

    prim_secded_inv_39_32_enc u_rd_enc (
        .data_i (retire_c.rdata),
        .data_o (rd_enc_c)
    );

    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        outstanding_d = outstanding_q;
        if (!req_i || gnt_o) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
        // A retiring response frees its credit only from the next cycle on.
        if (accept_c && !rvalid_q) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!accept_c && rvalid_q) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q    <= '0;
            outstanding_q <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            rintg_q       <= IntgOfZero;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            outstanding_q <= outstanding_d;
            rvalid_q      <= retire_c.valid;
            if (retire_c.valid) begin
                rdata_q <= retire_c.rdata;
                err_q   <= retire_c.err;
                rintg_q <= rd_enc_c[38:32];
            end
        end
    end

    assign rvalid_o     = rvalid_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;
    assign rdata_intg_o = rintg_q;

endmodule
